// File: rtl/cart_bus_pkg.sv
// Shared types and address-map constants for the CPU-side cartridge bus initiator.
package cart_bus_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} cbm_state_t;

  localparam logic [15:0] CART_BASE_DEFAULT = 16'h4020;
  localparam logic [15:0] ROM_BASE          = 16'h8000;
  localparam logic [15:0] PRGRAM_BASE       = 16'h6000;

  // Phase counter never narrower than one bit, even when a half-cycle is a single tick.
  function automatic int phase_w(input int clk_per_cycle);
    return (clk_per_cycle / 2 > 1) ? $clog2(clk_per_cycle / 2) : 1;
  endfunction

endpackage

// File: rtl/cart_bus_master_if.sv
// NES cartridge bus as seen from the CPU side: master drives the cycle, slave is the cart/mapper.
interface cart_bus_master_if;

  logic        m2;
  logic [14:0] cpu_addr;
  logic        cpu_rw;
  logic        romsel;
  logic [7:0]  cpu_data_o;
  logic        cpu_data_oe;
  logic [7:0]  cart_data_i;
  logic        cart_irq;

  modport master (
    output m2, cpu_addr, cpu_rw, romsel, cpu_data_o, cpu_data_oe,
    input  cart_data_i, cart_irq
  );

  modport slave (
    input  m2, cpu_addr, cpu_rw, romsel, cpu_data_o, cpu_data_oe,
    output cart_data_i, cart_irq
  );

endinterface

// File: rtl/sync_2ff_edge.sv
// Two-flop synchroniser for a 1-bit async level, with a registered rising-edge pulse.
module sync_2ff_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);

  logic meta_p0;

  // rise is aligned with q: it looks one flop ahead at the value q is about to take
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_p0 <= 1'b0;
      q       <= 1'b0;
      rise    <= 1'b0;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
      rise    <= meta_p0 & ~q;
    end
  end

endmodule

// File: rtl/cart_bus_master.sv
// CPU-side cartridge bus initiator: single-byte requests become registered m2/romsel bus cycles.
module cart_bus_master
  import cart_bus_pkg::*;
#(
  parameter int          CLK_PER_CYCLE = 4,
  parameter logic [15:0] CART_BASE     = CART_BASE_DEFAULT
) (
  input  logic                      clk_cpu,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [15:0]               req_addr,
  input  logic                      req_we,
  input  logic [7:0]                req_wdata,
  output logic                      rsp_valid,
  output logic [7:0]                rsp_rdata,
  output logic                      rsp_err,
  cart_bus_master_if.master         bus,
  output logic                      irq_o,
  output logic                      irq_rise
);

  localparam int              HALF    = CLK_PER_CYCLE / 2;
  localparam int              PH_W    = phase_w(CLK_PER_CYCLE);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF - 1);

  cbm_state_t      state_q, state_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic [15:0]     addr_q, addr_d;
  logic            we_q, we_d;
  logic [7:0]      wdata_q, wdata_d;

  logic        m2_q, m2_d;
  logic [14:0] cpu_addr_q, cpu_addr_d;
  logic        cpu_rw_q, cpu_rw_d;
  logic        romsel_q, romsel_d;
  logic [7:0]  cpu_data_q, cpu_data_d;
  logic        oe_q, oe_d;
  logic        ready_d, rsp_valid_d, rsp_err_d;
  logic [7:0]  rsp_rdata_d;
  logic        accept, bus_active, strobe;

  assign accept = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    cpu_addr_d  = cpu_addr_q;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = req_addr;
          we_d    = req_we;
          wdata_d = req_wdata;
          if (req_addr < CART_BASE) begin
            state_d     = DONE;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 8'h00;
          end else begin
            state_d    = SETUP;
            ph_d       = '0;
            cpu_addr_d = req_addr[14:0];
          end
        end
      end
      SETUP: begin
        if (ph_q == PH_LAST) begin
          state_d = STROBE;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      STROBE: begin
        if (ph_q == PH_LAST) begin
          state_d     = DONE;
          rsp_rdata_d = we_q ? 8'h00 : bus.cart_data_i;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bus outputs are derived from the state being entered so every pin comes straight off a flop
    bus_active  = (state_d == SETUP) || (state_d == STROBE);
    strobe      = (state_d == STROBE);
    m2_d        = strobe;
    romsel_d    = strobe && (addr_d >= ROM_BASE);
    cpu_rw_d    = ~(bus_active && we_d);
    oe_d        = strobe && we_d;
    cpu_data_d  = strobe ? wdata_d : cpu_data_q;
    ready_d     = (state_d == IDLE);
    rsp_valid_d = (state_d == DONE);
  end

  // Request latches carry data only; they are always reloaded on accept
  always_ff @(posedge clk_cpu) begin
    addr_q  <= addr_d;
    we_q    <= we_d;
    wdata_q <= wdata_d;
  end

  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      state_q    <= IDLE;
      ph_q       <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 8'h00;
      rsp_err    <= 1'b0;
      m2_q       <= 1'b0;
      cpu_addr_q <= '0;
      cpu_rw_q   <= 1'b1;
      romsel_q   <= 1'b0;
      cpu_data_q <= 8'h00;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      req_ready  <= ready_d;
      rsp_valid  <= rsp_valid_d;
      rsp_rdata  <= rsp_rdata_d;
      rsp_err    <= rsp_err_d;
      m2_q       <= m2_d;
      cpu_addr_q <= cpu_addr_d;
      cpu_rw_q   <= cpu_rw_d;
      romsel_q   <= romsel_d;
      cpu_data_q <= cpu_data_d;
      oe_q       <= oe_d;
    end
  end

  assign bus.m2          = m2_q;
  assign bus.cpu_addr    = cpu_addr_q;
  assign bus.cpu_rw      = cpu_rw_q;
  assign bus.romsel      = romsel_q;
  assign bus.cpu_data_o  = cpu_data_q;
  assign bus.cpu_data_oe = oe_q;

  sync_2ff_edge u_irq_sync (
    .clk  (clk_cpu),
    .rst  (rst),
    .d    (bus.cart_irq),
    .q    (irq_o),
    .rise (irq_rise)
  );

endmodule

// File: doc/cart_bus_master.md
Name: cart_bus_master

Overview:
- CPU-side initiator for the cartridge bus; the counterpart of the mapper blocks (e.g. MMC3), which are bus responders.
- Turns single-byte requests (from the CPU core or the ROM loader) into NES bus cycles: m2 phase, cpu_addr[14:0], cpu_rw, romsel, write data.
- Captures read data and returns it on a response strobe.
- Synchronises the cartridge IRQ line back into the CPU clock domain.

Parameters:
- CLK_PER_CYCLE, 4, clk_cpu ticks per bus cycle; even, >= 2. First half m2=0, second half m2=1.
- CART_BASE, 16'h4020, lowest address decoded as cartridge space.

Ports:
- clk_cpu  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_addr  in  16  CPU address.
- req_we  in  1  1 = write, 0 = read.
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-tick completion pulse.
- rsp_rdata  out  8  read data; 0 for writes and errors.
- rsp_err  out  1  qualifies rsp_valid; address below CART_BASE.
- m2  out  1  bus phase 2.
- cpu_addr  out  15  req_addr[14:0].
- cpu_rw  out  1  1 = read.
- romsel  out  1  active-high ROM select, equal to req_addr[15] & m2.
- cpu_data_o  out  8  write data.
- cpu_data_oe  out  1  drive enable for cpu_data_o.
- cart_data_i  in  8  data returned by the cart.
- cart_irq  in  1  async, active-high IRQ from the mapper.
- irq_o  out  1  synchronised IRQ level.
- irq_rise  out  1  one-tick pulse on each synchronised rising edge.

Behaviour:
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, m2=0, cpu_addr=0, cpu_rw=1, romsel=0, cpu_data_o=0, cpu_data_oe=0, irq_o=0, irq_rise=0; synchroniser flops 0.
- States: IDLE, SETUP, STROBE, DONE. Phase counter width is clog2(CLK_PER_CYCLE/2).
- IDLE:
  - req_ready=1; bus idle (m2=0, romsel=0, cpu_rw=1, oe=0).
  - On accept, latch addr/we/wdata into registers; all bus outputs are registered.
  - Address < CART_BASE -> DONE directly; no bus activity, rsp_err=1.
  - Otherwise -> SETUP.
- SETUP, CLK_PER_CYCLE/2 ticks:
  - m2=0, romsel=0; cpu_addr and cpu_rw (=~we) valid from the first tick.
- STROBE, CLK_PER_CYCLE/2 ticks:
  - m2=1, romsel=addr[15]; cpu_data_oe=we, cpu_data_o=wdata.
  - Read: cart_data_i is sampled on the final STROBE tick.
- DONE, 1 tick:
  - m2=0, romsel=0, oe=0, cpu_rw=1; cpu_addr holds the last value.
  - rsp_valid=1 with rdata/err; req_ready=0; next state IDLE.
- Latency: accept to rsp_valid = CLK_PER_CYCLE+1 ticks for cart addresses, 1 tick for errors. Back-to-back issue rate is one transaction per CLK_PER_CYCLE+2 ticks.
- Non-ROM cart space ($4020-$7FFF): full bus cycle with romsel=0. The mapper decodes PRG-RAM from ~romsel and cpu_addr[14:13].
- rsp_rdata is updated only by reads; writes and errors return 0.
- No request is accepted outside IDLE; req_* is ignored while busy.
- rst in any state: next edge forces all outputs to reset values. An aborted request produces no rsp_valid.
- IRQ path:
  - 2-flop synchroniser, so irq_o follows cart_irq after 2 ticks.
  - irq_rise = irq_o_next & ~irq_o, registered with irq_o.
  - Independent of the state machine.

Decomposition:
- Package cart_bus_pkg holds:
  - typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} cbm_state_t;
  - localparams CART_BASE_DEFAULT = 16'h4020, ROM_BASE = 16'h8000, PRGRAM_BASE = 16'h6000.
- One sub-module, sync_2ff_edge: 1-bit synchroniser with rising-edge pulse output, used for cart_irq.

Test Plan:
- Write $8000=0x46, N=4 -> SETUP 2 ticks (addr=0x0000, rw=0, romsel=0); STROBE 2 ticks (m2=1, romsel=1, oe=1, data=0x46); rsp_valid 5 ticks after accept, err=0, rdata=0.
- Read $E001, cart_data_i=0xA5 on the last STROBE tick (0x00 earlier) -> rsp_rdata=0xA5; cpu_addr=0x6001, rw=1, oe=0 throughout.
- Read $6000, cart_data_i=0x3C -> romsel stays 0 for the whole cycle, m2 pulses, cpu_addr=0x6000, rsp_rdata=0x3C.
- Read $2002 -> no m2/romsel activity; rsp_valid 1 tick after accept, rsp_err=1, rdata=0.
- rst asserted on the second STROBE tick of a write -> next tick m2=0, romsel=0, oe=0, rw=1, req_ready=1; no rsp_valid pulse ever.
- cart_irq 0->1 mid-transaction -> irq_o=1 two ticks later, irq_rise single pulse, transaction timing unchanged. cart_irq 1->0 -> irq_o=0 two ticks later, no pulse.
- Back-to-back: req_valid held with 3 writes -> accepts spaced exactly 6 ticks apart (N=4), 3 rsp pulses in order.
